// File: rtl/gate_timing_pkg.sv
// gate_timing_pkg: shared types and defaults for the gate timing monitor.
// Holds the result index enum, the FSM state enum and width defaults.
package gate_timing_pkg;

  localparam int CNT_W_DEFAULT    = 8;
  localparam int NUM_MEAS_DEFAULT = 4;

  typedef enum logic [1:0] {
    TPDR = 2'd0,
    TPDF = 2'd1,
    TCDR = 2'd2,
    TCDF = 2'd3
  } meas_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sync2.sv
// sync2: W-bit two-flop synchronizer, async active-low reset.
// Ports: clk, rst_n, d (async in), q (synced out).
module sync2
  import gate_timing_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/gate_timing_monitor.sv
// gate_timing_monitor: measures first/last Y change per stimulus step.
// Ports: clk, rst_n, a..d, y, valid in; meas_* valid/ready result out.
module gate_timing_monitor
  import gate_timing_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int NUM_MEAS = NUM_MEAS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        a,
  input  logic                        b,
  input  logic                        c,
  input  logic                        d,
  input  logic                        y,
  input  logic                        valid,
  input  logic                        meas_ready,
  output logic                        meas_valid,
  output logic [$clog2(NUM_MEAS)-1:0] meas_idx,
  output logic [CNT_W-1:0]            t_first,
  output logic [CNT_W-1:0]            t_last,
  output logic                        y_final,
  output logic                        timeout,
  output logic                        overrun,
  output logic                        seq_done
);

  localparam int IW = $clog2(NUM_MEAS);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_MEAS - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [5:0] sv;

  sync2 #(.W(6)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({a, b, c, d, y, valid}),
    .q     (sv)
  );

  logic [3:0] in_s;
  logic [3:0] in_p;
  logic       y_s;
  logic       y_p;
  logic       v_s;
  logic       v_p;

  assign in_s = sv[5:2];
  assign y_s  = sv[1];
  assign v_s  = sv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_p <= '0;
      y_p  <= 1'b0;
      v_p  <= 1'b0;
    end else begin
      in_p <= in_s;
      y_p  <= y_s;
      v_p  <= v_s;
    end
  end

  logic in_chg;
  logic y_chg;
  logic v_rise;

  assign in_chg = (in_s != in_p);
  assign y_chg  = y_s ^ y_p;
  assign v_rise = v_s & ~v_p;

  state_e           state;
  logic             active;
  logic             act_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] first;
  logic [CNT_W-1:0] last;
  logic             have_edge;

  logic             sat;
  logic             edge_c;
  logic [CNT_W-1:0] first_c;
  logic [CNT_W-1:0] last_c;
  logic             tmo_c;
  logic             cap;
  logic             drop;
  logic             acc;

  // Result view for this cycle: a Y edge coincident with the
  // valid rise is folded in before capture.
  assign sat     = &cnt;
  assign edge_c  = have_edge | y_chg;
  assign first_c = have_edge ? first : cnt;
  assign last_c  = y_chg ? cnt : last;
  assign tmo_c   = ~edge_c | sat;

  assign cap  = (state == ST_COUNT) & v_rise;
  assign drop = (state == ST_HOLD) & v_rise;
  assign acc  = meas_valid & meas_ready;

  // Capture closes the count; a same-cycle input change
  // restarts it after the capture.
  always_comb begin
    act_n = active;
    if (cap | drop) act_n = 1'b0;
    if (in_chg)     act_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      cnt       <= '0;
      first     <= '0;
      last      <= '0;
      have_edge <= 1'b0;
    end else begin
      active <= act_n;
      if (in_chg) begin
        cnt       <= ONE;
        have_edge <= y_chg;
        first     <= '0;
        last      <= '0;
      end else if (active) begin
        if (!sat) cnt <= cnt + ONE;
        if (y_chg) begin
          last <= cnt;
          if (!have_edge) begin
            first     <= cnt;
            have_edge <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      meas_valid <= 1'b0;
      meas_idx   <= '0;
      t_first    <= '0;
      t_last     <= '0;
      y_final    <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_chg) state <= ST_COUNT;
        end
        ST_COUNT: begin
          if (v_rise) begin
            t_first    <= tmo_c ? '1 : first_c;
            t_last     <= tmo_c ? '1 : last_c;
            y_final    <= y_s;
            timeout    <= tmo_c;
            meas_valid <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (drop) overrun <= 1'b1;
          if (acc) begin
            meas_valid <= 1'b0;
            if (meas_idx == IDX_LAST) begin
              meas_idx <= '0;
              seq_done <= 1'b1;
            end else begin
              meas_idx <= meas_idx + IDX_ONE;
            end
            state <= act_n ? ST_COUNT : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_timing_monitor.sv
// tb_gate_timing_monitor: scoreboard bench for gate_timing_monitor.
// Directed steps push expected results; a monitor pops on handshake.
module tb_gate_timing_monitor;

  logic       clk;
  logic       rst_n;
  logic       a, b, c, d, y, valid;
  logic       meas_ready;
  logic       meas_valid;
  logic [1:0] meas_idx;
  logic [7:0] t_first;
  logic [7:0] t_last;
  logic       y_final;
  logic       timeout;
  logic       overrun;
  logic       seq_done;

  gate_timing_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .y          (y),
    .valid      (valid),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .meas_idx   (meas_idx),
    .t_first    (t_first),
    .t_last     (t_last),
    .y_final    (y_final),
    .timeout    (timeout),
    .overrun    (overrun),
    .seq_done   (seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int tf;
    int tl;
    int yf;
    int to;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", n, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int tf, input int tl,
                      input int yf, input int to);
    exp_t e;
    e.idx = idx;
    e.tf  = tf;
    e.tl  = tl;
    e.yf  = yf;
    e.to  = to;
    q.push_back(e);
  endtask

  // Change inputs at cycle 0, toggle y at each set bit k of tmask,
  // raise valid at cycle vdly.
  task automatic step(input logic [3:0] v, input logic [31:0] tmask,
                      input int vdly);
    {a, b, c, d} = v;
    for (int k = 1; k <= vdly; k++) begin
      tick();
      if (k < 32 && tmask[k]) y = ~y;
    end
    valid = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_n && meas_valid && meas_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: actual idx=%0d required none",
                 meas_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_idx", 32'(meas_idx), e.idx);
        chk("res_t_first", 32'(t_first), e.tf);
        chk("res_t_last", 32'(t_last), e.tl);
        chk("res_y_final", 32'(y_final), e.yf);
        chk("res_timeout", 32'(timeout), e.to);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    {a, b, c, d} = 4'b0000;
    y          = 1'b0;
    valid      = 1'b0;
    meas_ready = 1'b1;
    rst_n      = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outputs",
          32'({meas_valid, meas_idx, t_first, t_last,
               y_final, timeout, overrun, seq_done}), 0);
    end

    // y = (a&b)|(c^d), following the inputs after 3 cycles
    push(0, 3, 3, 1, 0);
    step(4'b1100, 32'h8, 4);
    push(1, 3, 3, 0, 0);
    step(4'b1000, 32'h8, 4);
    push(2, 3, 3, 1, 0);
    step(4'b1010, 32'h8, 4);
    push(3, 3, 3, 0, 0);
    step(4'b1000, 32'h8, 4);
    repeat (6) tick();
    chk("seq_done_set", 32'(seq_done), 1);
    chk("no_overrun", 32'(overrun), 0);

    push(0, 1, 5, 1, 0);
    step(4'b0001, 32'h26, 7);
    push(1, 255, 255, 1, 1);
    step(4'b0011, 32'h0, 4);
    push(2, 255, 255, 0, 1);
    step(4'b0111, 32'h4, 300);
    push(3, 3, 3, 1, 0);
    step(4'b1111, 32'h8, 4);
    repeat (4) tick();

    meas_ready = 1'b0;
    push(0, 3, 3, 0, 0);
    step(4'b1110, 32'h8, 4);
    step(4'b1101, 32'h8, 4);
    repeat (2) tick();
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_held_valid", 32'(meas_valid), 1);
    chk("ovr_held_idx", 32'(meas_idx), 0);
    chk("ovr_held_t_first", 32'(t_first), 3);
    chk("ovr_held_y_final", 32'(y_final), 0);
    meas_ready = 1'b1;
    push(1, 3, 3, 0, 0);
    step(4'b1011, 32'h8, 4);
    repeat (6) tick();

    meas_ready = 1'b0;
    step(4'b0110, 32'h8, 4);
    repeat (2) tick();
    chk("hold_valid", 32'(meas_valid), 1);
    chk("hold_idx", 32'(meas_idx), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs",
        32'({meas_valid, meas_idx, t_first, t_last,
             y_final, timeout, overrun, seq_done}), 0);
    repeat (2) tick();
    rst_n      = 1'b1;
    meas_ready = 1'b1;
    repeat (4) tick();
    push(0, 3, 3, 0, 0);
    step(4'b0101, 32'h8, 4);
    repeat (6) tick();
    chk("seq_done_after_rst", 32'(seq_done), 0);
    chk("overrun_after_rst", 32'(overrun), 0);
    chk("pending_results", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
